// File: rtl/wb_mport_arb.sv
// wb_mport_arb
// Round-robin Wishbone arbiter that lets NCH masters share the single slave
// port of the SDRAM controller. Ownership is held for the whole cyc, which
// keeps cti bursts intact. Read data is broadcast to every master, and ack is
// routed only to the owner.
// Optional stall watchdog: define WB_ARB_TIMEOUT_EN to enable it. When it is
// enabled, a grant that sees TO_CYCLES consecutive un-acked strobes is aborted
// for one cycle and the owner gets an m_err_o pulse.
module wb_mport_arb #(
    parameter int NCH       = 4,
    parameter int DW        = 32,
    parameter int AW        = 26,
    parameter int TO_CYCLES = 255
) (
    input  logic                  sys_clk,
    input  logic                  RESET,
    // master-side channels
    input  logic [NCH-1:0]        m_cyc_i,
    input  logic [NCH-1:0]        m_stb_i,
    input  logic [NCH-1:0]        m_we_i,
    input  logic [NCH*AW-1:0]     m_addr_i,
    input  logic [NCH*DW-1:0]     m_dat_i,
    input  logic [NCH*DW/8-1:0]   m_sel_i,
    input  logic [NCH*3-1:0]      m_cti_i,
    output logic [NCH-1:0]        m_ack_o,
    output logic [NCH-1:0]        m_err_o,
    output logic [DW-1:0]         m_dat_o,
    // slave side
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [AW-1:0]         s_addr_o,
    output logic [DW-1:0]         s_dat_o,
    output logic [DW/8-1:0]       s_sel_o,
    output logic [2:0]            s_cti_o,
    input  logic                  s_ack_i,
    input  logic [DW-1:0]         s_dat_i,
    // registered one-hot grant
    output logic [NCH-1:0]        gnt_o
);

    localparam int SW = DW / 8;
    localparam int IW = $clog2(NCH);

    // Elaboration-time guard against unsupported configurations.
    if (NCH < 2 || NCH > 8 || (DW != 8 && DW != 16 && DW != 32) ||
        TO_CYCLES < 2 || TO_CYCLES > 65535) begin : g_bad_param
        $error("wb_mport_arb: parameter out of supported range");
    end

`ifdef WB_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_e;
`else
    typedef enum logic {IDLE, BUSY} state_e;
`endif

    state_e          state_q, state_d;
    logic [NCH-1:0]  gnt_q,   gnt_d;     // one-hot owner, visible on gnt_o
    logic [IW-1:0]   gidx_q,  gidx_d;    // binary owner index, drives the muxes
    logic [IW-1:0]   last_q,  last_d;    // previous owner, round-robin origin

`ifdef WB_ARB_TIMEOUT_EN
    logic [15:0]     cnt_q,   cnt_d;     // consecutive stalled strobe cycles
`endif

    logic            pick_vld;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   cand;
    logic [31:0]     gsel;

    assign gsel    = 32'(gidx_q);
    assign gnt_o   = gnt_q;
    assign m_dat_o = s_dat_i;

    // Round-robin search: first requester found walking upward from last+1,
    // wrapping at NCH, so the previous owner is always considered last.
    always_comb begin
        // NOTE: every variable gets a default before any branch; otherwise a
        // path that skips an assignment infers a latch.
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = last_q;
        for (int i = 0; i < NCH; i++) begin
            cand = (cand == IW'(NCH - 1)) ? '0 : cand + IW'(1);
            if (!pick_vld && m_cyc_i[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    // Next-state logic: grant in IDLE, hold in BUSY until the owner drops
    // cyc, and optionally abort a grant whose strobes go unanswered.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
`ifdef WB_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = BUSY;
                    gidx_d  = pick_idx;
                    gnt_d   = NCH'(1) << pick_idx;
                end
            end
            BUSY: begin
                if (!m_cyc_i[gidx_q]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    last_d  = gidx_q;
                end
`ifdef WB_ARB_TIMEOUT_EN
                else if (m_stb_i[gidx_q] && !s_ack_i) begin
                    // The TO_CYCLES-th consecutive stall ends the grant; the
                    // counter clears on any ack or idle strobe via its default.
                    if (cnt_q == 16'(TO_CYCLES - 1)) begin
                        state_d = ABORT;
                        gnt_d   = '0;
                        last_d  = gidx_q;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
`endif
            end
`ifdef WB_ARB_TIMEOUT_EN
            ABORT: begin
                state_d = IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and grant registers; async reset leaves channel 0 first in line.
    always_ff @(posedge sys_clk or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            gidx_q  <= '0;
            last_q  <= IW'(NCH - 1);
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            state_q <= state_d;
            gnt_q   <= gnt_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    // Watchdog stall counter.
    always_ff @(posedge sys_clk or posedge RESET) begin
        if (RESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // Slave-side mux and ack/err routing. Everything here is decoded from the
    // registered state, so a reset drops s_cyc_o without waiting for a clock.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_addr_o = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        s_cti_o  = '0;
        m_ack_o  = '0;
        m_err_o  = '0;
        case (state_q)
            BUSY: begin
                s_cyc_o         = m_cyc_i[gidx_q];
                s_stb_o         = m_stb_i[gidx_q];
                s_we_o          = m_we_i[gidx_q];
                s_addr_o        = m_addr_i[gsel*AW +: AW];
                s_dat_o         = m_dat_i[gsel*DW +: DW];
                s_sel_o         = m_sel_i[gsel*SW +: SW];
                s_cti_o         = m_cti_i[gsel*3 +: 3];
                m_ack_o[gidx_q] = s_ack_i;
            end
`ifdef WB_ARB_TIMEOUT_EN
            ABORT: begin
                m_err_o[gidx_q] = 1'b1;
            end
`endif
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_wb_mport_arb.sv
// tb_wb_mport_arb
// Directed bench for wb_mport_arb (4 channels, 32-bit data, 26-bit address).
// A vector table covers the single-master transfer, re-grant of a lone
// requester, four-way contention and burst locking. Hand-written sequences
// cover fairness, reset in the middle of a burst and the stall watchdog
// (the watchdog sequence follows WB_ARB_TIMEOUT_EN).
module tb_wb_mport_arb;

    localparam int NCH = 4;
    localparam int DW  = 32;
    localparam int AW  = 26;
    localparam int SW  = DW / 8;
    localparam int TO  = 16;

    logic               sys_clk = 1'b0;
    logic               RESET;
    logic [NCH-1:0]     m_cyc_i;
    logic [NCH-1:0]     m_stb_i;
    logic [NCH-1:0]     m_we_i;
    logic [NCH*AW-1:0]  m_addr_i;
    logic [NCH*DW-1:0]  m_dat_i;
    logic [NCH*SW-1:0]  m_sel_i;
    logic [NCH*3-1:0]   m_cti_i;
    logic [NCH-1:0]     m_ack_o;
    logic [NCH-1:0]     m_err_o;
    logic [DW-1:0]      m_dat_o;
    logic               s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0]      s_addr_o;
    logic [DW-1:0]      s_dat_o;
    logic [SW-1:0]      s_sel_o;
    logic [2:0]         s_cti_o;
    logic               s_ack_i;
    logic [DW-1:0]      s_dat_i;
    logic [NCH-1:0]     gnt_o;

    // Fixed per-channel transaction attributes.
    logic [AW-1:0] ch_addr [NCH];
    logic [DW-1:0] ch_dat  [NCH];
    logic [SW-1:0] ch_sel  [NCH];
    logic          ch_we   [NCH];
    logic [2:0]    ch_cti  [NCH];

    logic [DW-1:0] rd_word;
    int            n_vec = 0;
    int            n_bad = 0;

    // Every master holds stb together with cyc.
    assign m_stb_i = m_cyc_i;

    always #5 sys_clk = ~sys_clk;

    wb_mport_arb #(
        .NCH      (NCH),
        .DW       (DW),
        .AW       (AW),
        .TO_CYCLES(TO)
    ) dut (
        .sys_clk (sys_clk),
        .RESET   (RESET),
        .m_cyc_i (m_cyc_i),
        .m_stb_i (m_stb_i),
        .m_we_i  (m_we_i),
        .m_addr_i(m_addr_i),
        .m_dat_i (m_dat_i),
        .m_sel_i (m_sel_i),
        .m_cti_i (m_cti_i),
        .m_ack_o (m_ack_o),
        .m_err_o (m_err_o),
        .m_dat_o (m_dat_o),
        .s_cyc_o (s_cyc_o),
        .s_stb_o (s_stb_o),
        .s_we_o  (s_we_o),
        .s_addr_o(s_addr_o),
        .s_dat_o (s_dat_o),
        .s_sel_o (s_sel_o),
        .s_cti_o (s_cti_o),
        .s_ack_i (s_ack_i),
        .s_dat_i (s_dat_i),
        .gnt_o   (gnt_o)
    );

    typedef struct {
        logic           rst;
        logic [NCH-1:0] req;
        logic           ack;
        logic [NCH-1:0] e_gnt;
        logic [NCH-1:0] e_ack;
        logic           e_cyc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic rst, input logic [NCH-1:0] req, input logic ack,
                               input logic [NCH-1:0] e_gnt, input logic [NCH-1:0] e_ack,
                               input logic e_cyc);
        vec_t r;
        r.rst   = rst;
        r.req   = req;
        r.ack   = ack;
        r.e_gnt = e_gnt;
        r.e_ack = e_ack;
        r.e_cyc = e_cyc;
        return r;
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Compares all outputs against the expected owner and control values.
    // The slave bus must carry the owner's attributes while gnt is set and
    // must be all zero otherwise.
    task automatic check_outs(input string tag, input logic [NCH-1:0] e_gnt,
                              input logic [NCH-1:0] e_ack, input logic [NCH-1:0] e_err,
                              input logic e_cyc);
        logic [1:0] ch;
        logic       hit;
        ch  = '0;
        hit = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            if (e_gnt[c]) begin
                ch  = 2'(c);
                hit = 1'b1;
            end
        end
        check({tag, " gnt_o"},   96'(gnt_o),   96'(e_gnt));
        check({tag, " m_ack_o"}, 96'(m_ack_o), 96'(e_ack));
        check({tag, " m_err_o"}, 96'(m_err_o), 96'(e_err));
        check({tag, " s_cyc/stb"}, 96'({s_cyc_o, s_stb_o}), 96'({e_cyc, e_cyc}));
        check({tag, " m_dat_o"}, 96'(m_dat_o), 96'(rd_word));
        if (hit)
            check({tag, " s_bus"},
                  96'({s_we_o, s_cti_o, s_sel_o, s_addr_o, s_dat_o}),
                  96'({ch_we[ch], ch_cti[ch], ch_sel[ch], ch_addr[ch], ch_dat[ch]}));
        else
            check({tag, " s_bus idle"},
                  96'({s_we_o, s_cti_o, s_sel_o, s_addr_o, s_dat_o}), 96'(0));
    endtask

    task automatic do_reset(input string tag);
        @(negedge sys_clk);
        RESET   = 1'b1;
        m_cyc_i = '0;
        s_ack_i = 1'b0;
        #1;
        check_outs(tag, '0, '0, '0, 1'b0);
        @(negedge sys_clk);
        RESET = 1'b0;
    endtask

    initial begin
        logic [NCH-1:0] owner;
        int             left0, left3;

        ch_addr = '{26'h0000040, 26'h0000100, 26'h0000200, 26'h0000300};
        ch_dat  = '{32'h1111_1111, 32'hDEAD_BEEF, 32'h2222_2222, 32'h3333_3333};
        ch_sel  = '{4'h1, 4'hF, 4'h3, 4'hC};
        ch_we   = '{1'b0, 1'b1, 1'b0, 1'b0};
        ch_cti  = '{3'b000, 3'b010, 3'b010, 3'b111};
        for (int c = 0; c < NCH; c++) begin
            m_addr_i[c*AW +: AW] = ch_addr[c];
            m_dat_i[c*DW +: DW]  = ch_dat[c];
            m_sel_i[c*SW +: SW]  = ch_sel[c];
            m_we_i[c]            = ch_we[c];
            m_cti_i[c*3 +: 3]    = ch_cti[c];
        end
        RESET   = 1'b1;
        m_cyc_i = '0;
        s_ack_i = 1'b0;
        rd_word = 32'hA500_0000;
        s_dat_i = rd_word;

        // Single master ch1: grant one cycle after cyc, ack two cycles later.
        tbl.push_back(v(1, 4'b0000, 0, 4'b0000, 4'b0000, 0));
        tbl.push_back(v(0, 4'b0010, 0, 4'b0000, 4'b0000, 0));
        tbl.push_back(v(0, 4'b0010, 0, 4'b0010, 4'b0000, 1));
        tbl.push_back(v(0, 4'b0010, 0, 4'b0010, 4'b0000, 1));
        tbl.push_back(v(0, 4'b0010, 1, 4'b0010, 4'b0010, 1));
        tbl.push_back(v(0, 4'b0000, 0, 4'b0010, 4'b0000, 0));
        tbl.push_back(v(0, 4'b0000, 0, 4'b0000, 4'b0000, 0));
        // A lone requester is re-granted even though it owned the bus last.
        tbl.push_back(v(0, 4'b0010, 0, 4'b0000, 4'b0000, 0));
        tbl.push_back(v(0, 4'b0010, 1, 4'b0010, 4'b0010, 1));
        tbl.push_back(v(0, 4'b0000, 0, 4'b0010, 4'b0000, 0));
        tbl.push_back(v(0, 4'b0000, 0, 4'b0000, 4'b0000, 0));
        // Four-way contention from reset: order 0,1,2,3 with a dead cycle between owners.
        tbl.push_back(v(1, 4'b0000, 0, 4'b0000, 4'b0000, 0));
        tbl.push_back(v(0, 4'b1111, 0, 4'b0000, 4'b0000, 0));
        tbl.push_back(v(0, 4'b1111, 1, 4'b0001, 4'b0001, 1));
        tbl.push_back(v(0, 4'b1110, 0, 4'b0001, 4'b0000, 0));
        tbl.push_back(v(0, 4'b1110, 0, 4'b0000, 4'b0000, 0));
        tbl.push_back(v(0, 4'b1110, 1, 4'b0010, 4'b0010, 1));
        tbl.push_back(v(0, 4'b1100, 0, 4'b0010, 4'b0000, 0));
        tbl.push_back(v(0, 4'b1100, 0, 4'b0000, 4'b0000, 0));
        tbl.push_back(v(0, 4'b1100, 1, 4'b0100, 4'b0100, 1));
        tbl.push_back(v(0, 4'b1000, 0, 4'b0100, 4'b0000, 0));
        tbl.push_back(v(0, 4'b1000, 0, 4'b0000, 4'b0000, 0));
        tbl.push_back(v(0, 4'b1000, 1, 4'b1000, 4'b1000, 1));
        tbl.push_back(v(0, 4'b0000, 0, 4'b1000, 4'b0000, 0));
        tbl.push_back(v(0, 4'b0000, 0, 4'b0000, 4'b0000, 0));
        // Burst lock: ch2 holds the bus for 8 beats while ch0 waits.
        tbl.push_back(v(1, 4'b0000, 0, 4'b0000, 4'b0000, 0));
        tbl.push_back(v(0, 4'b0100, 0, 4'b0000, 4'b0000, 0));
        for (int b = 0; b < 8; b++)
            tbl.push_back(v(0, 4'b0101, 1, 4'b0100, 4'b0100, 1));
        tbl.push_back(v(0, 4'b0001, 0, 4'b0100, 4'b0000, 0));
        tbl.push_back(v(0, 4'b0001, 0, 4'b0000, 4'b0000, 0));
        tbl.push_back(v(0, 4'b0001, 1, 4'b0001, 4'b0001, 1));
        tbl.push_back(v(0, 4'b0000, 0, 4'b0001, 4'b0000, 0));
        tbl.push_back(v(0, 4'b0000, 0, 4'b0000, 4'b0000, 0));

        foreach (tbl[i]) begin
            @(negedge sys_clk);
            RESET   = tbl[i].rst;
            m_cyc_i = tbl[i].req;
            s_ack_i = tbl[i].ack;
            rd_word = 32'hA500_0000 + 32'(i);
            s_dat_i = rd_word;
            #1;
            check_outs($sformatf("vec%0d", i), tbl[i].e_gnt, tbl[i].e_ack, '0, tbl[i].e_cyc);
        end

        // Fairness: ch0 and ch3 each run 10 single reads and re-request at once.
        do_reset("fair rst");
        left0 = 10;
        left3 = 10;
        owner = 4'b0001;
        for (int r = 0; r < 20; r++) begin
            @(negedge sys_clk);
            m_cyc_i = {left3 > 0, 2'b00, left0 > 0};
            s_ack_i = 1'b0;
            #1;
            check_outs($sformatf("fair%0d idle", r), '0, '0, '0, 1'b0);
            @(negedge sys_clk);
            s_ack_i = 1'b1;
            #1;
            check_outs($sformatf("fair%0d ack", r), owner, owner, '0, 1'b1);
            if (owner[0]) left0--;
            else          left3--;
            @(negedge sys_clk);
            s_ack_i = 1'b0;
            m_cyc_i = m_cyc_i & ~owner;
            #1;
            check_outs($sformatf("fair%0d rel", r), owner, '0, '0, 1'b0);
            owner = (owner == 4'b0001) ? 4'b1000 : 4'b0001;
        end
        @(negedge sys_clk);
        m_cyc_i = '0;
        #1;
        check_outs("fair end", '0, '0, '0, 1'b0);

        // Reset asserted during beat 3 of a ch1 burst drops the bus immediately.
        do_reset("mrst rst");
        @(negedge sys_clk);
        m_cyc_i = 4'b0010;
        #1;
        check_outs("mrst idle", '0, '0, '0, 1'b0);
        for (int b = 1; b <= 3; b++) begin
            @(negedge sys_clk);
            s_ack_i = 1'b1;
            #1;
            check_outs($sformatf("mrst beat%0d", b), 4'b0010, 4'b0010, '0, 1'b1);
        end
        #1;
        RESET = 1'b1;
        #1;
        check_outs("mrst async", '0, '0, '0, 1'b0);
        @(negedge sys_clk);
        RESET   = 1'b0;
        s_ack_i = 1'b0;
        m_cyc_i = 4'b0011;
        #1;
        check_outs("mrst idle2", '0, '0, '0, 1'b0);
        @(negedge sys_clk);
        #1;
        check_outs("mrst regrant", 4'b0001, '0, '0, 1'b1);
        @(negedge sys_clk);
        m_cyc_i = '0;

        // Stalled slave: ch2 never gets an ack while ch3 waits.
        do_reset("to rst");
        @(negedge sys_clk);
        m_cyc_i = 4'b0100;
        #1;
        check_outs("to idle", '0, '0, '0, 1'b0);
`ifdef WB_ARB_TIMEOUT_EN
        for (int n = 1; n <= TO; n++) begin
            @(negedge sys_clk);
            m_cyc_i = 4'b1100;
            #1;
            check_outs($sformatf("to stall%0d", n), 4'b0100, '0, '0, 1'b1);
        end
        @(negedge sys_clk);
        #1;
        check_outs("to abort", '0, '0, 4'b0100, 1'b0);
        @(negedge sys_clk);
        m_cyc_i = 4'b1000;
        #1;
        check_outs("to after", '0, '0, '0, 1'b0);
        @(negedge sys_clk);
        #1;
        check_outs("to ch3", 4'b1000, '0, '0, 1'b1);
`else
        @(negedge sys_clk);
        m_cyc_i = 4'b1100;
        #1;
        check_outs("hold first", 4'b0100, '0, '0, 1'b1);
        repeat (1000) @(negedge sys_clk);
        #1;
        check_outs("hold 1000", 4'b0100, '0, '0, 1'b1);
        @(negedge sys_clk);
        m_cyc_i = 4'b1000;
        #1;
        check_outs("hold rel", 4'b0100, '0, '0, 1'b0);
        @(negedge sys_clk);
        #1;
        check_outs("hold dead", '0, '0, '0, 1'b0);
        @(negedge sys_clk);
        #1;
        check_outs("hold ch3", 4'b1000, '0, '0, 1'b1);
`endif
        @(negedge sys_clk);
        m_cyc_i = '0;
        repeat (2) @(negedge sys_clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
